// File: rtl/cla_seq_ctrl.sv
// Multi-cycle adder: one WIDTH-bit carry-lookahead slice adds CHUNKS chunks, one per cycle.
// Optional build macro LOWER_PART_OR_EN makes chunk 0 an approximate OR instead of an exact add.
module cla_seq_ctrl #(
  parameter int unsigned WIDTH  = 12,
  parameter int unsigned CHUNKS = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic [WIDTH*CHUNKS-1:0]    add1_i,
  input  logic [WIDTH*CHUNKS-1:0]    add2_i,
  input  logic                       carry_i,
  input  logic                       in_valid_i,
  output logic                       in_ready_o,
  output logic [WIDTH*CHUNKS:0]      result_o,
  output logic                       out_valid_o,
  input  logic                       out_ready_i,
  output logic                       busy_o
);

  localparam int unsigned TW = WIDTH * CHUNKS;
  localparam int unsigned KW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e          state_q, state_d;
  logic [TW-1:0]   a_q, b_q;
  logic            carry_q;
  logic [KW-1:0]   k_q;
  logic [TW:0]     result_q;

  logic [WIDTH-1:0] a_chunk, b_chunk, g, p, sum;
  logic [WIDTH:0]   c;
  logic             term;
  logic             chunk_cout;
  logic             last_chunk;
  logic             accept;

  assign a_chunk    = a_q[k_q*WIDTH +: WIDTH];
  assign b_chunk    = b_q[k_q*WIDTH +: WIDTH];
  assign last_chunk = (k_q == KW'(CHUNKS - 1));
  assign accept     = (state_q == StIdle) && in_valid_i;

  // Each carry is a flat sum of products over generate/propagate terms, no ripple chain.
  always_comb begin
    g = a_chunk & b_chunk;
    p = a_chunk | b_chunk;
    c = '0;
    term = 1'b0;
    for (int i = 0; i <= WIDTH; i++) begin
      term = carry_q;
      for (int m = 0; m < i; m++) term = term & p[m];
      c[i] = term;
      for (int j = 0; j < i; j++) begin
        term = g[j];
        for (int m = j + 1; m < i; m++) term = term & p[m];
        c[i] = c[i] | term;
      end
    end
    sum        = a_chunk ^ b_chunk ^ c[WIDTH-1:0];
    chunk_cout = c[WIDTH];
`ifdef LOWER_PART_OR_EN
    if (k_q == '0) begin
      sum        = p;
      chunk_cout = a_chunk[WIDTH-1] & b_chunk[WIDTH-1];
    end
`endif
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:  if (in_valid_i) state_d = StRun;
      StRun:   if (last_chunk) state_d = StDone;
      StDone:  if (out_ready_i) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q  <= StIdle;
      a_q      <= '0;
      b_q      <= '0;
      carry_q  <= 1'b0;
      k_q      <= '0;
      result_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        a_q     <= add1_i;
        b_q     <= add2_i;
        carry_q <= carry_i;
        k_q     <= '0;
      end else if (state_q == StRun) begin
        result_q[k_q*WIDTH +: WIDTH] <= sum;
        carry_q                      <= chunk_cout;
        if (last_chunk) result_q[TW] <= chunk_cout;
        else            k_q          <= k_q + KW'(1);
      end
    end
  end

  assign in_ready_o  = (state_q == StIdle);
  assign out_valid_o = (state_q == StDone);
  assign busy_o      = (state_q != StIdle);
  assign result_o    = result_q;

endmodule

// File: tb/tb_cla_seq_ctrl.sv
// Scoreboard bench for cla_seq_ctrl: accepts push model results, a monitor pops on handshakes.
// Honours LOWER_PART_OR_EN so the reference model matches the build under test.
module tb_cla_seq_ctrl;

  localparam int unsigned WIDTH  = 12;
  localparam int unsigned CHUNKS = 4;
  localparam int unsigned TW     = WIDTH * CHUNKS;

  logic          clk_i = 1'b0;
  logic          rst_n_i;
  logic [TW-1:0] add1_i, add2_i;
  logic          carry_i;
  logic          in_valid_i;
  logic          in_ready_o;
  logic [TW:0]   result_o;
  logic          out_valid_o;
  logic          out_ready_i;
  logic          busy_o;

  cla_seq_ctrl #(.WIDTH(WIDTH), .CHUNKS(CHUNKS)) dut (
    .clk_i       (clk_i),
    .rst_n_i     (rst_n_i),
    .add1_i      (add1_i),
    .add2_i      (add2_i),
    .carry_i     (carry_i),
    .in_valid_i  (in_valid_i),
    .in_ready_o  (in_ready_o),
    .result_o    (result_o),
    .out_valid_o (out_valid_o),
    .out_ready_i (out_ready_i),
    .busy_o      (busy_o)
  );

  always #5 clk_i = ~clk_i;

  typedef struct {
    logic [TW:0] res;
    int          acc;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   cyc = 0;
  bit   b2b = 1'b0;
  int   last_acc = -1;

  function automatic logic [TW:0] model(logic [TW-1:0] a, logic [TW-1:0] b, logic c);
    logic [TW:0] r;
`ifdef LOWER_PART_OR_EN
    logic [TW-WIDTH:0] hi;
    hi = {1'b0, a[TW-1:WIDTH]} + {1'b0, b[TW-1:WIDTH]}
       + {{(TW-WIDTH){1'b0}}, a[WIDTH-1] & b[WIDTH-1]};
    r = {hi, a[WIDTH-1:0] | b[WIDTH-1:0]};
    r[0] = r[0] | (c & 1'b0);
`else
    r = {1'b0, a} + {1'b0, b} + {{TW{1'b0}}, c};
`endif
    return r;
  endfunction

  function automatic logic [TW-1:0] rnd_op();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 4))
      0:       return '1;
      1:       return '0;
      default: return r[TW-1:0];
    endcase
  endfunction

  task automatic chk(input string name, input logic [TW:0] got, input logic [TW:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic chk_int(input string name, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, got, exp);
    end
  endtask

  initial forever @(posedge clk_i) cyc++;

  // Monitor: inputs change only at posedge+1, so negedge values are what the next edge samples.
  initial begin
    bit          prev_valid;
    logic [TW:0] prev_res;
    prev_valid = 1'b0;
    prev_res   = '0;
    forever begin
      @(negedge clk_i);
      if (!rst_n_i) begin
        prev_valid = 1'b0;
      end else begin
        if (out_valid_o) begin
          chk("in_ready_in_done", {{TW{1'b0}}, in_ready_o}, '0);
          if (!prev_valid) begin
            if (sb.size() == 0) begin
              chk_int("unexpected_result", 1, 0);
            end else begin
              chk("result", result_o, sb[0].res);
              chk_int("latency", cyc - sb[0].acc, CHUNKS);
            end
          end else begin
            chk("result_stable", result_o, prev_res);
          end
          if (out_ready_i && sb.size() != 0) void'(sb.pop_front());
        end
        if (in_valid_i && in_ready_o) begin
          if (b2b && last_acc >= 0) chk_int("b2b_spacing", cyc + 1 - last_acc, CHUNKS + 2);
          last_acc = cyc + 1;
          sb.push_back('{res: model(add1_i, add2_i, carry_i), acc: cyc + 1});
        end
        prev_valid = out_valid_o;
        prev_res   = result_o;
      end
    end
  end

  task automatic issue(input logic [TW-1:0] a, input logic [TW-1:0] b, input logic c);
    bit ok;
    ok = 1'b0;
    in_valid_i = 1'b1;
    add1_i = a;
    add2_i = b;
    carry_i = c;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (in_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk_int("accept_timeout", 0, 1);
    @(posedge clk_i);
    #1 in_valid_i = 1'b0;
  endtask

  task automatic wait_valid();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk_i);
      if (out_valid_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) chk_int("out_valid_timeout", 0, 1);
  endtask

  task automatic run_vec(input string name, input logic [TW-1:0] a, input logic [TW-1:0] b,
                         input logic c, input logic [TW:0] exp);
    issue(a, b, c);
    wait_valid();
    chk(name, result_o, exp);
  endtask

  task automatic drain();
    out_ready_i = 1'b1;
    in_valid_i  = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(posedge clk_i);
      #1;
      if (sb.size() == 0 && !busy_o) break;
    end
    chk_int("drain_empty", sb.size(), 0);
  endtask

  initial begin
    logic [TW-1:0] a1, b1;
    logic          c1;
    rst_n_i = 1'b0;
    add1_i = '0;
    add2_i = '0;
    carry_i = 1'b0;
    in_valid_i = 1'b0;
    out_ready_i = 1'b1;
    #3;
    chk("rst_result", result_o, '0);
    chk("rst_out_valid", {{TW{1'b0}}, out_valid_o}, '0);
    chk("rst_busy", {{TW{1'b0}}, busy_o}, '0);
    chk("rst_in_ready", {{TW{1'b0}}, in_ready_o}, 1);
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;

`ifdef LOWER_PART_OR_EN
    run_vec("vec_ones_plus_one", '1, 48'h1, 1'b0, 49'h0FFFFFFFFFFFF);
    run_vec("vec_msb_low", 48'h800, 48'h800, 1'b0, 49'h0000000001800);
`else
    run_vec("vec_ones_plus_one", '1, 48'h1, 1'b0, 49'h1000000000000);
    run_vec("vec_max_overflow", '1, '1, 1'b1, 49'h1FFFFFFFFFFFF);
`endif
    drain();

    // Backpressure in DONE
    out_ready_i = 1'b0;
    issue(rnd_op(), rnd_op(), 1'($urandom));
    wait_valid();
    repeat (5) begin
      @(negedge clk_i);
      chk("bp_out_valid", {{TW{1'b0}}, out_valid_o}, 1);
    end
    @(posedge clk_i);
    #1 out_ready_i = 1'b1;
    @(posedge clk_i);
    #1;
    chk("bp_in_ready_after", {{TW{1'b0}}, in_ready_o}, 1);
    drain();

    // New requests while running must be ignored
    a1 = rnd_op();
    b1 = rnd_op();
    c1 = 1'($urandom);
    issue(a1, b1, c1);
    in_valid_i = 1'b1;
    repeat (2) begin
      add1_i = rnd_op();
      add2_i = rnd_op();
      carry_i = 1'($urandom);
      @(posedge clk_i);
      #1;
    end
    in_valid_i = 1'b0;
    wait_valid();
    chk("busy_reject", result_o, model(a1, b1, c1));
    drain();

    // Reset at k=2 mid-run
    issue(rnd_op(), rnd_op(), 1'b1);
    @(posedge clk_i);
    @(posedge clk_i);
    #1 rst_n_i = 1'b0;
    #1;
    chk("midrst_result", result_o, '0);
    chk("midrst_out_valid", {{TW{1'b0}}, out_valid_o}, '0);
    chk("midrst_busy", {{TW{1'b0}}, busy_o}, '0);
    chk("midrst_in_ready", {{TW{1'b0}}, in_ready_o}, 1);
    sb.delete();
    @(posedge clk_i);
    #1 rst_n_i = 1'b1;
`ifdef LOWER_PART_OR_EN
    run_vec("after_reset", 48'h5, 48'h7, 1'b1, 49'h7);
`else
    run_vec("after_reset", 48'h5, 48'h7, 1'b1, 49'hD);
`endif
    drain();

    // Back-to-back with valid and ready held high
    last_acc = -1;
    b2b = 1'b1;
    in_valid_i = 1'b1;
    repeat (30) begin
      add1_i = rnd_op();
      add2_i = rnd_op();
      carry_i = 1'($urandom);
      @(posedge clk_i);
      #1;
    end
    in_valid_i = 1'b0;
    b2b = 1'b0;
    drain();

    // Random traffic with random backpressure
    repeat (400) begin
      in_valid_i  = 1'($urandom);
      out_ready_i = ($urandom_range(0, 3) != 0);
      add1_i = rnd_op();
      add2_i = rnd_op();
      carry_i = 1'($urandom);
      @(posedge clk_i);
      #1;
    end
    drain();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/cla_seq_ctrl.md
CLA_SEQ_CTRL -- requirements
Module: cla_seq_ctrl

Interface
REQ-001 SHALL have parameter WIDTH, default 12, chunk width in bits processed per cycle by one internal carry-lookahead adder.
REQ-002 SHALL have parameter CHUNKS, default 4, number of chunks per operand; the total operand width TW is WIDTH*CHUNKS.
REQ-003 SHALL have port clk_i, input, 1 bit: the single clock, with all state changing on the rising edge.
REQ-004 SHALL have port rst_n_i, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port add1_i, input, TW bits: operand A, sampled on accept.
REQ-006 SHALL have port add2_i, input, TW bits: operand B, sampled on accept.
REQ-007 SHALL have port carry_i, input, 1 bit: carry-in, sampled on accept.
REQ-008 SHALL have port in_valid_i, input, 1 bit: the requester presents an operation.
REQ-009 SHALL have port in_ready_o, output, 1 bit: the block can accept an operation.
REQ-010 SHALL have port result_o, output, TW+1 bits: {carry-out, sum}.
REQ-011 SHALL have port out_valid_o, output, 1 bit: result_o is valid.
REQ-012 SHALL have port out_ready_i, input, 1 bit: the consumer takes the result.
REQ-013 SHALL have port busy_o, output, 1 bit: high in any state other than IDLE.

Function
REQ-014 SHALL implement a three-state FSM with states IDLE, RUN and DONE.
REQ-015 SHALL drive in_ready_o=1 only in IDLE; an operation is accepted on the edge where in_valid_i and in_ready_o are both 1.
REQ-016 SHALL, on accept, register add1_i, add2_i and carry_i, clear chunk counter k to 0, and move from IDLE to RUN.
REQ-017 SHALL, in RUN, add chunk k of A and B plus the registered carry each cycle using one WIDTH-bit CLA (generate = a&b, propagate = a|b, ripple-free lookahead), write the sum to result chunk k and register the chunk carry-out.
REQ-018 SHALL, in RUN with k=CHUNKS-1, write result_o[TW] with the final carry-out and move to DONE; otherwise k increments by 1.
REQ-019 SHALL assert out_valid_o exactly CHUNKS cycles after the accept edge, with latency fixed and independent of the data.
REQ-020 SHALL hold out_valid_o and result_o stable in DONE until out_ready_i=1, then return to IDLE on that edge.
REQ-021 SHALL NOT accept a new operation in the same cycle as the DONE handshake; the earliest next accept is in the following cycle.
REQ-022 SHALL keep result_o at its last value after returning to IDLE and update it only during RUN.
REQ-023 SHALL ignore in_valid_i and operand changes while in RUN or DONE.
REQ-024 SHALL cause no overflow loss: the sum of two all-ones operands plus carry_i=1 yields all-ones with result_o[TW]=1.

Reset
REQ-025 SHALL, on rst_n_i=0 and regardless of clk_i, force state IDLE, k=0, result_o=0, out_valid_o=0, busy_o=0, in_ready_o=1 and clear the operand and carry registers.
REQ-026 SHALL abort any operation interrupted by reset mid-RUN or in DONE without emitting a result; the first accept after deassertion behaves as a cold start.

Configuration
REQ-027 SHALL, when macro LOWER_PART_OR_EN is defined, compute chunk 0 as the bitwise OR of A[WIDTH-1:0] and B[WIDTH-1:0], with carry into chunk 1 = A[WIDTH-1]&B[WIDTH-1] and carry_i ignored, making the result approximate.
REQ-028 SHALL, when LOWER_PART_OR_EN is undefined, compute chunk 0 with the exact CLA and carry_i, making the result exact.
REQ-029 SHALL keep latency, handshake and FSM identical in both builds.

Verification (WIDTH=12, CHUNKS=4)
REQ-030 Exact build: A=0xFFFFFFFFFFFF, B=0x000000000001, cin=0 -> out_valid_o high 4 cycles after accept with result_o=0x1000000000000.
REQ-031 LOWER_PART_OR_EN build, same operands -> result_o=0x0FFFFFFFFFFFF; A=0x000000000800, B=0x000000000800 -> 0x0000000001800.
REQ-032 Backpressure: out_ready_i=0 for 5 cycles in DONE -> result_o and out_valid_o stable and in_ready_o=0 throughout; in_ready_o=1 the cycle after out_ready_i=1.
REQ-033 Busy rejection: in_valid_i held high with new operands during RUN -> no second accept; the first result is unaffected.
REQ-034 Reset at k=2 in RUN -> all outputs return to reset values immediately; a new op A=5, B=7, cin=1 then yields 0x000000000000D.
REQ-035 Back-to-back: in_valid_i held high with out_ready_i=1 -> accepts spaced exactly CHUNKS+2 cycles apart, with every result correct.
